// File: rtl/synapse_weight_loader_if.sv
// Bundle of the serial configuration handshake and the committed weight bus
// for synapse_weight_loader. The master side (configuration controller)
// drives framing and serial data. The slave side (the loader) returns the
// committed matrix and its status.
interface synapse_weight_loader_if #(
    parameter int ROWS  = 5,
    parameter int COLS  = 3,
    parameter int WBITS = 4
);
    localparam int TOTAL = ROWS * COLS * WBITS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic               start;
    logic               bit_in;
    logic               bit_valid;
    logic               abort;
    logic [0:TOTAL-1]   phi_out;
    logic               wgt_valid;
    logic               done;
    logic               busy;
    logic               err;
    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   cur_col;

    modport master (
        output start, bit_in, bit_valid, abort,
        input  phi_out, wgt_valid, done, busy, err, cur_row, cur_col
    );

    modport slave (
        input  start, bit_in, bit_valid, abort,
        output phi_out, wgt_valid, done, busy, err, cur_row, cur_col
    );
endinterface

// File: rtl/synapse_weight_loader.sv
// Serial-to-parallel loader for the ROWS x COLS synapse weight matrix.
// Bits arrive MSB first, row-major, into a shadow register. The complete
// frame is copied to phi_out in a single COMMIT cycle, so the neuron array
// never sees a partially loaded matrix.
// Optional feature: define WEIGHT_PARITY_CHECK_EN to require one trailing
// even-parity bit after the data. On a parity mismatch the frame is dropped
// and the sticky err flag is set. Without the macro, err is tied to 0.
module synapse_weight_loader #(
    parameter int ROWS  = 5,
    parameter int COLS  = 3,
    parameter int WBITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    synapse_weight_loader_if.slave  bus
);
    localparam int TOTAL = ROWS * COLS * WBITS;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int SUB_W = (WBITS > 1) ? $clog2(WBITS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(WBITS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

`ifdef WEIGHT_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd3
    } state_t;
`endif

    state_t             state;
    logic [0:TOTAL-1]   shadow;
    logic [0:TOTAL-1]   phi_q;
    logic               wgt_valid_q;
    logic               done_q;
    logic               busy_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SUB_W-1:0]   sub_cnt;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
`ifdef WEIGHT_PARITY_CHECK_EN
    logic               err_q;
`endif

    // Frame sequencer. Every output is registered here. In SHIFT and PARITY,
    // abort is checked before data so that it overrides a simultaneous
    // last bit. On the final data bit the position counters are not
    // advanced, so cur_row/cur_col keep pointing at the last weight after
    // commit until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            phi_q       <= '0;
            wgt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bit_cnt     <= '0;
            sub_cnt     <= '0;
            row_q       <= '0;
            col_q       <= '0;
`ifdef WEIGHT_PARITY_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SHIFT;
                        busy_q  <= 1'b1;
                        shadow  <= '0;
                        bit_cnt <= '0;
                        sub_cnt <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
`ifdef WEIGHT_PARITY_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.bit_valid) begin
                        shadow[bit_cnt] <= bus.bit_in;
                        if (bit_cnt == LAST_BIT) begin
`ifdef WEIGHT_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= COMMIT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (sub_cnt == SUB_LAST) begin
                                sub_cnt <= '0;
                                if (col_q == COL_LAST) begin
                                    col_q <= '0;
                                    row_q <= row_q + 1'b1;
                                end else begin
                                    col_q <= col_q + 1'b1;
                                end
                            end else begin
                                sub_cnt <= sub_cnt + 1'b1;
                            end
                        end
                    end
                end

`ifdef WEIGHT_PARITY_CHECK_EN
                PARITY: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.bit_valid) begin
                        if (bus.bit_in == (^shadow)) begin
                            state <= COMMIT;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end
                    end
                end
`endif

                COMMIT: begin
                    phi_q       <= shadow;
                    wgt_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phi_out   = phi_q;
    assign bus.wgt_valid = wgt_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cur_row   = row_q;
    assign bus.cur_col   = col_q;
`ifdef WEIGHT_PARITY_CHECK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Self-checking bench for synapse_weight_loader: a table of directed frames,
// randomized frames checked against a weight-level model, and hand-written
// sequences for asynchronous reset and (when enabled) parity handling.
module tb_synapse_weight_loader;
    localparam int ROWS  = 5;
    localparam int COLS  = 3;
    localparam int WBITS = 4;
    localparam int TOTAL = ROWS * COLS * WBITS;
    localparam int NW    = ROWS * COLS;
`ifdef WEIGHT_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    synapse_weight_loader_if #(.ROWS(ROWS), .COLS(COLS), .WBITS(WBITS)) bus ();

    synapse_weight_loader #(.ROWS(ROWS), .COLS(COLS), .WBITS(WBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [WBITS-1:0] w [NW];
    logic [0:TOTAL-1] model_phi = '0;
    logic             model_wv  = 1'b0;

    typedef struct {
        string            name;
        logic [WBITS-1:0] wa;
        logic [WBITS-1:0] wb;
        int               gap_a;
        int               gap_b;
        int               gap_len;
        int               abort_after;
        bit               abort_last;
        bit               exp_commit;
        int               exp_lat;
    } vec_t;

    vec_t tbl [6];

    // done is a one-cycle pulse, so each pulse is seen on exactly one falling edge.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Matrix layout: weight(i,j) sits at [(i*COLS+j)*WBITS +: WBITS], MSB at lowest index.
    function automatic logic [0:TOTAL-1] expected_phi();
        logic [0:TOTAL-1] p;
        p = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                p[(i*COLS+j)*WBITS +: WBITS] = w[i*COLS+j];
        return p;
    endfunction

    function automatic logic frame_parity();
        logic p;
        p = 1'b0;
        for (int k = 0; k < NW; k++) p = p ^ (^w[k]);
        return p;
    endfunction

    // Streams the frame held in w. Gaps are inserted after bits gap_a and gap_b.
    task automatic stream(input int gap_a, input int gap_b, input int gap_len,
                          input int abort_after, input bit abort_last,
                          input bit bad_par, output int ticks);
        ticks = 0;
        bus.start = 1'b1;
        tick(); ticks++;
        bus.start = 1'b0;
        for (int n = 1; n <= TOTAL; n++) begin
            int wi;
            int k;
            wi = (n - 1) / WBITS;
            k  = (n - 1) % WBITS;
            bus.bit_valid = 1'b1;
            bus.bit_in    = w[wi][WBITS-1-k];
            if (abort_last && n == TOTAL) bus.abort = 1'b1;
            tick(); ticks++;
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'b0;
            bus.abort     = 1'b0;
            if (abort_last && n == TOTAL) return;
            if (n == abort_after) begin
                bus.abort = 1'b1;
                tick(); ticks++;
                bus.abort = 1'b0;
                return;
            end
            if (n == gap_a || n == gap_b) begin
                for (int g = 0; g < gap_len; g++) begin
                    check("gap_row", 64'(bus.cur_row), 64'(n / (COLS*WBITS)));
                    check("gap_col", 64'(bus.cur_col), 64'((n % (COLS*WBITS)) / WBITS));
                    tick(); ticks++;
                end
            end
        end
        if (PAR) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = frame_parity() ^ bad_par;
            tick(); ticks++;
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output int ticks, output bit seen);
        ticks = 0;
        seen  = 1'b0;
        while (ticks < budget && !seen) begin
            tick(); ticks++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_case(input string name, input int gap_a, input int gap_b,
                            input int gap_len, input int abort_after,
                            input bit abort_last, input bit bad_par,
                            input bit exp_commit, input int exp_lat);
        int t1;
        int t2;
        bit seen;
        int dc0;
        bit aborted;
        aborted = (abort_after != 0) || abort_last;
        dc0 = done_cnt;
        stream(gap_a, gap_b, gap_len, abort_after, abort_last, bad_par, t1);
        if (exp_commit) begin
            wait_done(8, t2, seen);
            check({name, "_done"}, 64'(seen), 64'd1);
            check({name, "_latency"}, 64'(t1 + t2), 64'(exp_lat + (PAR ? 1 : 0)));
            model_phi = expected_phi();
            model_wv  = 1'b1;
        end else begin
            check({name, "_busy_drop"}, 64'(bus.busy), 64'd0);
            repeat (3) tick();
        end
        check({name, "_phi"}, 64'(bus.phi_out), 64'(model_phi));
        check({name, "_wgt_valid"}, 64'(bus.wgt_valid), 64'(model_wv));
        check({name, "_err"}, 64'(bus.err), 64'(PAR && bad_par && !aborted));
        tick();
        check({name, "_done_pulses"}, 64'(done_cnt - dc0), 64'(exp_commit));
        check({name, "_busy_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.abort     = 1'b0;

        tbl[0] = '{"rows_f00",      4'hF, 4'h0, 0, 0,  0, 0,  1'b0, 1'b1, 62};
        tbl[1] = '{"rows_f00_gaps", 4'hF, 4'h0, 7, 30, 3, 0,  1'b0, 1'b1, 68};
        tbl[2] = '{"all_ones",      4'hF, 4'hF, 0, 0,  0, 0,  1'b0, 1'b1, 62};
        tbl[3] = '{"abort_20",      4'h5, 4'hA, 0, 0,  0, 20, 1'b0, 1'b0, 0};
        tbl[4] = '{"abort_last",    4'h3, 4'hC, 0, 0,  0, 0,  1'b1, 1'b0, 0};
        tbl[5] = '{"mixed_a5",      4'hA, 4'h5, 0, 0,  0, 0,  1'b0, 1'b1, 62};

        // Reset state
        repeat (2) tick();
        check("rst_phi", 64'(bus.phi_out), 64'd0);
        check("rst_wgt_valid", 64'(bus.wgt_valid), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_row", 64'(bus.cur_row), 64'd0);
        check("rst_col", 64'(bus.cur_col), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NW; k++)
                w[k] = (k % COLS == 0) ? tbl[i].wa : tbl[i].wb;
            run_case(tbl[i].name, tbl[i].gap_a, tbl[i].gap_b, tbl[i].gap_len,
                     tbl[i].abort_after, tbl[i].abort_last, 1'b0,
                     tbl[i].exp_commit, tbl[i].exp_lat);
            if (i == 0) begin
                logic [0:TOTAL-1] p;
                p = bus.phi_out;
                check("slice_0_3", 64'(p[0:3]), 64'hF);
                check("slice_4_11", 64'(p[4:11]), 64'h0);
                check("slice_12_15", 64'(p[12:15]), 64'hF);
            end
        end

        // Asynchronous reset in the middle of a frame
        for (int k = 0; k < NW; k++) w[k] = 4'($urandom_range(0, 15));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = w[(n-1)/WBITS][WBITS-1-((n-1)%WBITS)];
            tick();
        end
        bus.bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_phi", 64'(bus.phi_out), 64'd0);
        check("midrst_wgt_valid", 64'(bus.wgt_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        model_phi = '0;
        model_wv  = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        for (int k = 0; k < NW; k++) w[k] = 4'($urandom_range(0, 15));
        run_case("after_reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 62);

`ifdef WEIGHT_PARITY_CHECK_EN
        // Parity: good bit commits, inverted bit flags err, next start clears it
        for (int k = 0; k < NW; k++) w[k] = 4'($urandom_range(0, 15));
        run_case("parity_ok", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 62);
        for (int k = 0; k < NW; k++) w[k] = 4'($urandom_range(0, 15));
        run_case("parity_bad", 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("parity_err_cleared", 64'(bus.err), 64'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("parity_abort_idle", 64'(bus.busy), 64'd0);
`endif

        // Randomized frames against the weight-level model
        for (int r = 0; r < 12; r++) begin
            int ga;
            int gb;
            int gl;
            int ab;
            bit al;
            bit bp;
            bit ec;
            int gaps;
            for (int k = 0; k < NW; k++) w[k] = 4'($urandom_range(0, 15));
            ga = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, TOTAL-1)) : 0;
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, TOTAL-1)) : 0;
            if (gb == ga) gb = 0;
            gl = int'($urandom_range(1, 4));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOTAL-1)) : 0;
            al = (ab == 0) && ($urandom_range(0, 5) == 0);
            bp = PAR && ($urandom_range(0, 3) == 0);
            ec = (ab == 0) && !al && !bp;
            gaps = ((ga != 0) ? gl : 0) + ((gb != 0) ? gl : 0);
            run_case("random", ga, gb, gl, ab, al, bp, ec, 1 + TOTAL + gaps + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/synapse_weight_loader.md
Name: synapse_weight_loader

Overview:
- Serial-to-parallel loader and sequencer for the synapse weight matrix.
- Frames a serial bit stream into ROWS x COLS weights of WBITS each, MSB first, row-major.
- Shadow-buffers the frame and commits it atomically to the packed weight bus feeding the neuron array, so neurons never see a partially loaded matrix.
- Sits between the serial configuration interface and the synapse/neuron datapath.

Parameters:
ROWS, 5, matrix rows
COLS, 3, matrix columns
WBITS, 4, bits per weight
TOTAL, ROWS*COLS*WBITS (60), derived frame length; localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new frame; sampled only in IDLE
bit_in  in  1  serial weight bit
bit_valid  in  1  bit_in is valid this cycle
abort  in  1  cancel the frame in progress
phi_out  out  [0:TOTAL-1]  committed weights; weight(i,j) occupies bits [(i*COLS+j)*WBITS +: WBITS], MSB at the lowest index
wgt_valid  out  1  high once any frame has been committed
done  out  1  one-cycle pulse on commit
busy  out  1  high when state is not IDLE
err  out  1  sticky frame error; cleared on accepted start
cur_row  out  $clog2(ROWS)  row index of the next expected bit
cur_col  out  $clog2(COLS)  column index of the next expected bit

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - phi_out=0, wgt_valid=0, done=0, busy=0, err=0.
  - Shadow register and all counters cleared.
- States: IDLE, SHIFT, PARITY (present only with the option), COMMIT.
- IDLE:
  - start=1 -> SHIFT on the next edge.
  - bit_cnt, cur_row, cur_col and the WBITS sub-counter are cleared; err is cleared.
  - bit_valid is ignored in IDLE.
- SHIFT:
  - Each cycle with bit_valid=1, bit_in is written to shadow[bit_cnt] and bit_cnt increments.
  - The sub-counter wraps at WBITS-1 and advances cur_col; cur_col wraps at COLS-1 and advances cur_row.
  - Gaps (bit_valid=0) are allowed and hold all counters.
  - start is ignored outside IDLE.
- Last bit: bit accepted with bit_cnt=TOTAL-1 -> COMMIT (or PARITY with the option).
- COMMIT:
  - Lasts exactly one cycle.
  - phi_out <= shadow, wgt_valid <= 1, done=1.
  - Next state is IDLE.
  - done and the new phi_out appear one cycle after the last bit is accepted.
- abort:
  - Applies in SHIFT or PARITY; the next state is IDLE.
  - The shadow is discarded, phi_out and wgt_valid are unchanged, and done stays 0.
  - abort in IDLE or COMMIT has no effect.
- Simultaneous abort and last bit: abort wins; no commit.
- Reset mid-frame: everything returns to reset values, including phi_out=0.
- busy is high in SHIFT, PARITY and COMMIT.
- cur_row and cur_col hold their final values after COMMIT until the next start.

Optional Feature:
- Macro: WEIGHT_PARITY_CHECK_EN.
- Defined:
  - After TOTAL data bits the FSM enters PARITY and waits for one more valid bit.
  - Even parity: that bit must equal the XOR of all TOTAL data bits.
  - Match -> COMMIT.
  - Mismatch -> err=1, no commit, next state IDLE, phi_out unchanged.
- Undefined:
  - The PARITY state and its logic are absent, and err is tied to 0.
  - The last data bit goes directly to COMMIT.

Test Plan:
- Reset, then start, then 60 valid bits as the pattern "1111 0000 0000" repeated per row x5 -> done pulses one cycle after bit 60; phi_out[0:3]=4'b1111, phi_out[4:11]=0, phi_out[12:15]=4'b1111, wgt_valid=1.
- Same frame with bit_valid deasserted for 3 cycles after bits 7 and 30 -> identical phi_out; done is delayed by 6 cycles; cur_row/cur_col correct during the gaps (after bit 7: row 0, col 1).
- Commit all-ones, then start a second frame and abort after 20 bits -> phi_out stays all-ones, no done, busy falls the cycle after abort.
- abort asserted on the same cycle as bit 60 -> no commit; phi_out keeps its previous value; state IDLE.
- rst_n pulsed low asynchronously mid-frame (bit 33) -> phi_out=0, wgt_valid=0, busy=0 immediately; a fresh frame then loads correctly.
- With WEIGHT_PARITY_CHECK_EN:
  - Correct parity bit -> commit.
  - Inverted parity bit -> err=1, no done, phi_out unchanged.
  - The next start clears err.
